heap_sort_vec_loader: RTL and testbench
=======================================

// Module: heap_sort_vec_loader
// PURPOSE
//   Upstream stage of the heap-sort datapath. Collects a serial stream of elements
//   (valid/ready) into one packed vector of N_ELEM elements, then presents it to the
//   sorter as a single-cycle strobe. Partial vectors can be closed early; unused slots
//   are padded with PAD_VAL so they sort to the end.
// PARAMETERS
//   ELEM_W   23              width of one element in bits
//   N_ELEM   7               elements per vector; ELEM_W*N_ELEM = 161 = sorter input width
//   PAD_VAL  {ELEM_W{1'b1}}  fill value for unused slots (maximum unsigned value)
// PORTS
//   system1000       in   1                clock, all logic on rising edge
//   system1000_rstn  in   1                asynchronous reset, active low
//   in_data          in   ELEM_W           element being offered
//   in_valid         in   1                in_data is valid
//   in_last          in   1                qualified by in_valid: this element closes the vector
//   in_ready         out  1                loader accepts in_data this cycle
//   flush_i          in   1                close the current partial vector without data
//   vec_o            out  ELEM_W*N_ELEM    packed vector to sorter; element k at [k*ELEM_W +: ELEM_W]
//   vec_valid_o      out  1                one-cycle strobe: vec_o holds a new vector
//   vec_count_o      out  clog2(N_ELEM+1)  real (non-pad) elements in vec_o, 1..N_ELEM
// BEHAVIOUR
//   Reset (async assert, sync release): state=FILL, count=0, assembly buffer=0,
//     vec_o=0, vec_valid_o=0, vec_count_o=0, in_ready=0 while reset is asserted.
//   Accept = in_valid & in_ready. The first accepted element goes to slot 0, the next to
//     slot 1, and so on. The assembly buffer is separate from the vec_o register.
//   FSM states:
//     FILL: in_ready=1. On accept, write slot[count] and increment count.
//       Go to EMIT if any of the following holds:
//         (a) the accept fills slot N_ELEM-1;
//         (b) the accept has in_last=1;
//         (c) flush_i=1 and count after this cycle's accept is >0.
//       flush_i with count==0 and no accept is ignored (no empty vector is ever emitted).
//       Simultaneous accept and flush_i: the element is included, then the vector is emitted.
//       in_last on the N_ELEM-th element behaves exactly like (a), with a single emit.
//     Transition to EMIT registers vec_o = buffer, with slots >= final count replaced by
//       PAD_VAL, and vec_count_o = final count.
//     EMIT: vec_valid_o=1 for exactly this one cycle; in_ready=0 (one-cycle bubble);
//       flush_i is ignored. The next cycle returns to FILL with count=0 and the buffer cleared.
//   Between strobes, vec_o and vec_count_o hold the last emitted values.
//   Latency: the final accepted element appears on vec_o with vec_valid_o on the next cycle.
//   Best-case throughput: one vector every N_ELEM+1 cycles.
//   Reset mid-fill discards the partial vector; no strobe is produced for it.
//   in_data/in_last are don't-care when in_valid=0; in_ready does not depend on in_valid.
// TESTING
//   1. Full vector: 7 back-to-back accepts with data 1..7 -> vec_valid_o one cycle after
//      the 7th; vec_o slots 0..6 = 1..7; vec_count_o=7; in_ready=0 that cycle.
//   2. Early in_last: accept 10,20 with in_last on 20 -> slots = 10,20,7FFFFF x5;
//      vec_count_o=2.
//   3. flush_i: with count=0 -> no strobe; after accepting 5, assert flush_i alone ->
//      slot0=5, rest 7FFFFF, vec_count_o=1.
//   4. Simultaneous accept of 9 with flush_i at count=3 -> vec_count_o=4, slot3=9;
//      in_last on the 7th element -> exactly one strobe.
//   5. Backpressure/gaps: in_valid toggled randomly while flush_i is pulsed during EMIT ->
//      order preserved, no extra strobe, vec_o stable between strobes.
//   6. Reset mid-fill: accept 3 elements, pulse system1000_rstn low for one cycle ->
//      all outputs 0 immediately; the next 7 accepts produce a clean vector containing only
//      the new data.

Source files
------------

// File: rtl/heap_sort_vec_loader.sv
// Serial-to-parallel loader for the heap sorter: packs up to N_ELEM streamed elements
// into one vector, pads unused slots with PAD_VAL and presents it as a one-cycle strobe.
module heap_sort_vec_loader #(
    parameter int                 ELEM_W  = 23,
    parameter int                 N_ELEM  = 7,
    parameter logic [ELEM_W-1:0]  PAD_VAL = {ELEM_W{1'b1}}
) (
    input  logic                            system1000,
    input  logic                            system1000_rstn,
    input  logic [ELEM_W-1:0]               in_data,
    input  logic                            in_valid,
    input  logic                            in_last,
    output logic                            in_ready,
    input  logic                            flush_i,
    output logic [ELEM_W*N_ELEM-1:0]        vec_o,
    output logic                            vec_valid_o,
    output logic [$clog2(N_ELEM+1)-1:0]     vec_count_o
);

    localparam int CNT_W = $clog2(N_ELEM + 1);

    typedef enum logic {FILL, EMIT} state_t;

    state_t                     state_reg, state_next;
    logic [CNT_W-1:0]           count_reg, count_next;
    logic [CNT_W-1:0]           count_after;
    logic [ELEM_W*N_ELEM-1:0]   vec_reg, vec_next;
    logic [CNT_W-1:0]           vec_count_reg;
    logic                       accept;
    logic                       full_hit;
    logic                       emit_go;

    // Ready is forced low while reset is held so nothing is accepted during reset.
    assign in_ready    = (state_reg == FILL) & system1000_rstn;
    assign accept      = in_valid & in_ready;
    assign count_after = count_reg + CNT_W'(accept);
    assign full_hit    = accept && (count_reg == CNT_W'(N_ELEM - 1));

    // Each slot keeps its own register; vec_next merges the element accepted this
    // cycle so the emitted vector already contains it.
    generate
        for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_slot
            logic [ELEM_W-1:0] slot_reg;
            logic              slot_wr;

            assign slot_wr = accept && (count_reg == CNT_W'(gi));

            always_ff @(posedge system1000 or negedge system1000_rstn) begin
                if (!system1000_rstn) begin
                    slot_reg <= '0;
                end else if (state_reg == EMIT) begin
                    slot_reg <= '0;
                end else if (slot_wr) begin
                    slot_reg <= in_data;
                end
            end

            assign vec_next[gi*ELEM_W +: ELEM_W] =
                slot_wr                     ? in_data  :
                (CNT_W'(gi) < count_after)  ? slot_reg :
                                              PAD_VAL;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        emit_go    = 1'b0;
        case (state_reg)
            FILL: begin
                count_next = count_after;
                if (full_hit || (accept && in_last) || (flush_i && (count_after != '0))) begin
                    emit_go    = 1'b1;
                    state_next = EMIT;
                end
            end
            EMIT: begin
                state_next = FILL;
                count_next = '0;
            end
            default: begin
                state_next = FILL;
                count_next = '0;
            end
        endcase
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_reg     <= FILL;
            count_reg     <= '0;
            vec_reg       <= '0;
            vec_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (emit_go) begin
                vec_reg       <= vec_next;
                vec_count_reg <= count_after;
            end
        end
    end

    assign vec_o       = vec_reg;
    assign vec_count_o = vec_count_reg;
    assign vec_valid_o = (state_reg == EMIT);

endmodule

// File: tb/tb_heap_sort_vec_loader.sv
// Directed bench for heap_sort_vec_loader: a queue of accepted elements models the
// expected vector, checked one cycle after the closing accept.
module tb_heap_sort_vec_loader;

    localparam int ELEM_W = 23;
    localparam int N_ELEM = 7;
    localparam int VEC_W  = ELEM_W * N_ELEM;
    localparam logic [ELEM_W-1:0] PAD = {ELEM_W{1'b1}};

    logic               clk;
    logic               rst_n;
    logic [ELEM_W-1:0]  in_data;
    logic               in_valid;
    logic               in_last;
    logic               in_ready;
    logic               flush_i;
    logic [VEC_W-1:0]   vec_o;
    logic               vec_valid_o;
    logic [2:0]         vec_count_o;

    int                 n_checks;
    int                 n_fail;
    int                 strobe_cnt;
    int                 strobe_mark;
    logic [ELEM_W-1:0]  exp_q[$];
    logic [VEC_W-1:0]   last_vec;

    heap_sort_vec_loader #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM), .PAD_VAL(PAD)) dut (
        .system1000      (clk),
        .system1000_rstn (rst_n),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_last         (in_last),
        .in_ready        (in_ready),
        .flush_i         (flush_i),
        .vec_o           (vec_o),
        .vec_valid_o     (vec_valid_o),
        .vec_count_o     (vec_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && vec_valid_o) strobe_cnt++;
    end

    task automatic check_eq(input string tag, input logic [VEC_W-1:0] got, input logic [VEC_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [ELEM_W-1:0] d, input logic last, input logic flush);
        check_eq("ready_before_push", VEC_W'(in_ready), VEC_W'(1));
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        flush_i  = flush;
        exp_q.push_back(d);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        flush_i  = 1'b0;
        in_data  = '0;
    endtask

    task automatic flush_pulse();
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
    endtask

    task automatic check_emit(input string tag);
        logic [VEC_W-1:0] exp_vec;
        for (int k = 0; k < N_ELEM; k++)
            exp_vec[k*ELEM_W +: ELEM_W] = (k < exp_q.size()) ? exp_q[k] : PAD;
        check_eq({tag, "_valid"}, VEC_W'(vec_valid_o), VEC_W'(1));
        check_eq({tag, "_ready"}, VEC_W'(in_ready), VEC_W'(0));
        check_eq({tag, "_count"}, VEC_W'(vec_count_o), VEC_W'(exp_q.size()));
        check_eq({tag, "_vec"}, vec_o, exp_vec);
        exp_q.delete();
        last_vec = exp_vec;
        idle(1);
        check_eq({tag, "_strobe_end"}, VEC_W'(vec_valid_o), VEC_W'(0));
        check_eq({tag, "_hold"}, vec_o, last_vec);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        strobe_cnt = 0;
        rst_n      = 1'b0;
        in_data    = '0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        flush_i    = 1'b0;
        last_vec   = '0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_vec", vec_o, '0);
        check_eq("rst_valid", VEC_W'(vec_valid_o), VEC_W'(0));
        check_eq("rst_count", VEC_W'(vec_count_o), VEC_W'(0));
        check_eq("rst_ready", VEC_W'(in_ready), VEC_W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // 1: full vector 1..7
        for (int i = 1; i <= 7; i++) push(ELEM_W'(i), 1'b0, 1'b0);
        check_emit("full");

        // 2: early in_last
        push(23'd10, 1'b0, 1'b0);
        push(23'd20, 1'b1, 1'b0);
        check_emit("last2");

        // 3: flush at count 0 is ignored, then flush after one element
        strobe_mark = strobe_cnt;
        flush_pulse();
        check_eq("flush_empty_valid", VEC_W'(vec_valid_o), VEC_W'(0));
        idle(2);
        check_eq("flush_empty_strobes", VEC_W'(strobe_cnt - strobe_mark), VEC_W'(0));
        check_eq("flush_empty_hold", vec_o, last_vec);
        push(23'd5, 1'b0, 1'b0);
        flush_pulse();
        check_emit("flush1");

        // 4: accept with flush at count 3, then in_last on the 7th element
        push(23'd1, 1'b0, 1'b0);
        push(23'd2, 1'b0, 1'b0);
        push(23'd3, 1'b0, 1'b0);
        push(23'd9, 1'b0, 1'b1);
        check_emit("acc_flush");
        strobe_mark = strobe_cnt;
        for (int i = 0; i < 6; i++) push(ELEM_W'(100 + i), 1'b0, 1'b0);
        push(23'h7FFFFE, 1'b1, 1'b0);
        check_emit("last7");
        idle(2);
        check_eq("last7_one_strobe", VEC_W'(strobe_cnt - strobe_mark), VEC_W'(1));

        // 5: gaps between accepts, flush pulsed during EMIT
        strobe_mark = strobe_cnt;
        for (int i = 0; i < 7; i++) begin
            idle($urandom_range(0, 2));
            push(ELEM_W'(23'h400000 + i * 3), 1'b0, 1'b0);
        end
        flush_i = 1'b1;
        check_emit("gaps");
        flush_i = 1'b0;
        idle(3);
        check_eq("gaps_stable", vec_o, last_vec);
        check_eq("gaps_one_strobe", VEC_W'(strobe_cnt - strobe_mark), VEC_W'(1));

        // 6: reset mid-fill
        push(23'd77, 1'b0, 1'b0);
        push(23'd78, 1'b0, 1'b0);
        push(23'd79, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_vec", vec_o, '0);
        check_eq("mid_rst_valid", VEC_W'(vec_valid_o), VEC_W'(0));
        check_eq("mid_rst_count", VEC_W'(vec_count_o), VEC_W'(0));
        check_eq("mid_rst_ready", VEC_W'(in_ready), VEC_W'(0));
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        strobe_mark = strobe_cnt;
        idle(1);
        for (int i = 0; i < 7; i++) push(ELEM_W'(23'h1000 + i), 1'b0, 1'b0);
        check_emit("post_rst");
        check_eq("post_rst_strobes", VEC_W'(strobe_cnt - strobe_mark), VEC_W'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
